// File: rtl/aud_sram_writer.sv
// aud_sram_writer
//   Takes the recorder's 16-bit sample stream (data + one-cycle valid pulse),
//   buffers it in a small FIFO and writes consecutive samples into an async
//   1M x 16 SRAM starting at address 0. Every write uses the same fixed
//   sequence: one setup cycle, WE_CYCLES cycles with we_n low, one hold cycle.
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_start, i_stop        one-cycle pulses that begin / end a recording
//   i_data, i_valid        sample stream from the recorder
//   o_sram_*               SRAM address, data, tristate enable and strobes
//   o_recording            high from start until the last write completes
//   o_word_count           words written since the last start
//   o_full, o_overflow     sticky status: MAX_WORDS reached / sample dropped
module aud_sram_writer #(
    parameter int ADDR_W     = 20,
    parameter int MAX_WORDS  = 1048576,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [15:0]       i_data,
    input  logic              i_valid,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_dq,
    output logic              o_sram_dq_oe,
    output logic              o_sram_we_n,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    output logic              o_recording,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_full,
    output logic              o_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PC_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_W:0] MAX_CNT   = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(MAX_WORDS - 1);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(WE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_DRAIN} ctrl_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_t;

    ctrl_t cstate, cnext;
    wr_t   wstate, wnext;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   cnt;
    logic [PC_W-1:0]  pulse_cnt;
    logic [15:0]      dq;
    logic [ADDR_W:0]  word_count;
    logic             full, overflow;

    logic fifo_empty, start_acc, hold_done, last_word, flush;
    logic pop, push_req, push_ok;

    assign fifo_empty = (cnt == '0);
    assign start_acc  = (cstate == S_IDLE) && i_start;
    assign hold_done  = (wstate == W_HOLD);
    // The write that takes the count to MAX_WORDS ends the recording at once.
    assign last_word  = hold_done && (word_count == LAST_CNT);
    assign flush      = start_acc || last_word;
    assign push_req   = (cstate == S_REC) && i_valid && !last_word;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push_ok    = push_req && ((cnt < DEPTH_CNT) || pop);

    always_comb begin
        wnext = wstate;
        pop   = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (!fifo_empty && !full) begin
                    pop   = 1'b1;
                    wnext = W_SETUP;
                end
            end
            W_SETUP: wnext = W_PULSE;
            W_PULSE: if (pulse_cnt == PULSE_LAST) wnext = W_HOLD;
            W_HOLD: begin
                if (last_word || fifo_empty) begin
                    wnext = W_IDLE;
                end else begin
                    pop   = 1'b1;
                    wnext = W_SETUP;
                end
            end
            default: wnext = W_IDLE;
        endcase
    end

    always_comb begin
        cnext = cstate;
        case (cstate)
            S_IDLE:  if (i_start) cnext = S_REC;
            S_REC: begin
                if (last_word)   cnext = S_IDLE;
                else if (i_stop) cnext = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_word || (fifo_empty && wstate == W_IDLE)) cnext = S_IDLE;
            end
            default: cnext = S_IDLE;
        endcase
    end

    // Sample storage needs no reset; occupancy lives in the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cstate     <= S_IDLE;
            wstate     <= W_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            pulse_cnt  <= '0;
            dq         <= '0;
            word_count <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cstate <= cnext;
            wstate <= wnext;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_ok, pop})
                    2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                    2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                    default: cnt <= cnt;
                endcase
            end

            if (pop) dq <= mem[rd_ptr];

            if (wstate == W_SETUP)      pulse_cnt <= '0;
            else if (wstate == W_PULSE) pulse_cnt <= pulse_cnt + PC_W'(1);

            if (start_acc)
                word_count <= '0;
            else if (hold_done && word_count != MAX_CNT)
                word_count <= word_count + (ADDR_W+1)'(1);

            if (start_acc)      full <= 1'b0;
            else if (last_word) full <= 1'b1;

            if (start_acc)                  overflow <= 1'b0;
            else if (push_req && !push_ok)  overflow <= 1'b1;
        end
    end

    // Strobes decode straight from the write state, so a reset edge releases
    // we_n on that same edge.
    assign o_sram_addr  = word_count[ADDR_W-1:0];
    assign o_sram_dq    = dq;
    assign o_sram_dq_oe = (wstate != W_IDLE);
    assign o_sram_we_n  = (wstate != W_PULSE);
    assign o_sram_ce_n  = (wstate == W_IDLE);
    assign o_sram_oe_n  = 1'b1;
    assign o_sram_lb_n  = (wstate == W_IDLE);
    assign o_sram_ub_n  = (wstate == W_IDLE);
    assign o_recording  = (cstate != S_IDLE);
    assign o_word_count = word_count;
    assign o_full       = full;
    assign o_overflow   = overflow;
endmodule
